// File: rtl/demux1to16_deser.sv
// Serial-to-parallel 1:16 demux: routes each accepted bit to a word position and publishes the word on position 15.
// Latency: out/out_valid register on the edge sampling the position-15 bit; no backpressure, a bit is accepted every cycle.
module demux1to16_deser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in,
  input  logic        in_valid,
  input  logic        load_sel,
  input  logic [3:0]  sel,
  input  logic        clr,
  output logic [15:0] out,
  output logic        out_valid,
  output logic [3:0]  pos,
  output logic        busy
);

  logic [15:0] acc_q, acc_d;
  logic [3:0]  pos_q, pos_d;
  logic [15:0] out_q, out_d;
  logic        out_valid_q, out_valid_d;
  logic [3:0]  tgt;
  logic [15:0] wr_word;

  always_comb begin
    tgt          = load_sel ? sel : pos_q;
    wr_word      = acc_q;
    wr_word[tgt] = in;
    acc_d        = acc_q;
    pos_d        = pos_q;
    out_d        = out_q;
    out_valid_d  = 1'b0;
    if (clr) begin
      acc_d = '0;
      pos_d = '0;
    end else if (in_valid) begin
      if (tgt == 4'd15) begin
        // Publish the merged word directly so the last bit needs no extra cycle.
        out_d       = wr_word;
        out_valid_d = 1'b1;
        acc_d       = '0;
        pos_d       = '0;
      end else begin
        acc_d = wr_word;
        pos_d = tgt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      pos_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      pos_q       <= pos_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign pos       = pos_q;
  assign busy      = (pos_q != 4'd0);

endmodule

// File: tb/tb_demux1to16_deser.sv
// Bench for demux1to16_deser: scenario tasks plus a strobe monitor fed by an expected-word queue.
module tb_demux1to16_deser;

  logic        clk;
  logic        rst_n;
  logic        in;
  logic        in_valid;
  logic        load_sel;
  logic [3:0]  sel;
  logic        clr;
  logic [15:0] out;
  logic        out_valid;
  logic [3:0]  pos;
  logic        busy;

  int passed;
  int total;
  int strobe_cnt;
  logic [15:0] sb_q[$];

  demux1to16_deser dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .in_valid (in_valid),
    .load_sel (load_sel),
    .sel      (sel),
    .clr      (clr),
    .out      (out),
    .out_valid(out_valid),
    .pos      (pos),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      logic [15:0] exp_w;
      strobe_cnt++;
      total++;
      if (sb_q.size() == 0) begin
        $display("FAIL spurious_strobe: got out=%h with no frame expected", out);
      end else begin
        exp_w = sb_q.pop_front();
        if (out !== exp_w) $display("FAIL sb_word: got %h expected %h", out, exp_w);
        else passed++;
      end
    end
  end

  task automatic send_bit(input logic b, input logic ls, input logic [3:0] s);
    in       = b;
    in_valid = 1'b1;
    load_sel = ls;
    sel      = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    load_sel = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0; load_sel = 1'b0; clr = 1'b0; in = 1'b0; sel = 4'd0;
    rst_n = 1'b0;
    #7;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_queue_empty(input string name);
    total++;
    if (sb_q.size() != 0) begin
      $display("FAIL %s_queue: got %0d pending expected 0", name, sb_q.size());
      sb_q.delete();
    end else passed++;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; load_sel = 1'b0; clr = 1'b0; in = 1'b0; sel = 4'd0;
    rst_n = 1'b0;
    #3;
    total++;
    if (out !== 16'h0000 || out_valid !== 1'b0 || pos !== 4'd0 || busy !== 1'b0)
      $display("FAIL reset_state: got out=%h ov=%b pos=%0d busy=%b expected 0000 0 0 0", out, out_valid, pos, busy);
    else passed++;
    do_reset();
  endtask

  task automatic test_basic();
    logic [15:0] w;
    int s0;
    w  = 16'hABCD;
    s0 = strobe_cnt;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] ep;
      ep = i[3:0];
      total++;
      if (pos !== ep || busy !== (i != 0))
        $display("FAIL basic_pos: got pos=%0d busy=%b expected %0d %b", pos, busy, ep, (i != 0));
      else passed++;
      if (i == 15) sb_q.push_back(w);
      send_bit(w[i], 1'b0, 4'd0);
    end
    total++;
    if (out_valid !== 1'b1 || out !== w || pos !== 4'd0 || busy !== 1'b0)
      $display("FAIL basic_done: got ov=%b out=%h pos=%0d busy=%b expected 1 %h 0 0", out_valid, out, pos, busy, w);
    else passed++;
    idle(1);
    total++;
    if (out_valid !== 1'b0 || out !== w)
      $display("FAIL basic_hold: got ov=%b out=%h expected 0 %h", out_valid, out, w);
    else passed++;
    total++;
    if (strobe_cnt - s0 !== 1) $display("FAIL basic_strobes: got %0d expected 1", strobe_cnt - s0);
    else passed++;
    check_queue_empty("basic");
  endtask

  task automatic test_gapped();
    logic [15:0] w;
    int s0;
    w  = 16'hABCD;
    do_reset();
    s0 = strobe_cnt;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) sb_q.push_back(w);
      send_bit(w[i], 1'b0, 4'd0);
      if (i != 15) idle($urandom_range(1, 3));
    end
    idle(4);
    total++;
    if (out !== w || strobe_cnt - s0 !== 1)
      $display("FAIL gapped: got out=%h strobes=%0d expected %h 1", out, strobe_cnt - s0, w);
    else passed++;
    check_queue_empty("gapped");
  endtask

  task automatic test_back_to_back();
    logic [31:0] ws;
    int s0;
    ws = {16'hFFFF, 16'h1234};
    s0 = strobe_cnt;
    for (int i = 0; i < 32; i++) begin
      logic eov;
      if (i == 15) sb_q.push_back(16'h1234);
      if (i == 31) sb_q.push_back(16'hFFFF);
      send_bit(ws[i], 1'b0, 4'd0);
      eov = (i == 15 || i == 31);
      total++;
      if (out_valid !== eov) $display("FAIL b2b_strobe_%0d: got %b expected %b", i, out_valid, eov);
      else passed++;
      if (i == 15 || i == 31) begin
        total++;
        if (out !== ((i == 15) ? 16'h1234 : 16'hFFFF))
          $display("FAIL b2b_word_%0d: got %h expected %h", i, out, (i == 15) ? 16'h1234 : 16'hFFFF);
        else passed++;
      end
    end
    idle(1);
    total++;
    if (strobe_cnt - s0 !== 2) $display("FAIL b2b_strobes: got %0d expected 2", strobe_cnt - s0);
    else passed++;
    check_queue_empty("b2b");
  endtask

  task automatic test_abort();
    logic [15:0] w;
    int s0;
    w  = 16'h00F0;
    s0 = strobe_cnt;
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0, 4'd0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    total++;
    if (pos !== 4'd0 || busy !== 1'b0 || out_valid !== 1'b0 || out !== 16'hFFFF)
      $display("FAIL abort_clr: got pos=%0d busy=%b ov=%b out=%h expected 0 0 0 ffff", pos, busy, out_valid, out);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        total++;
        if (out !== 16'hFFFF) $display("FAIL abort_hold: got %h expected ffff", out);
        else passed++;
      end
      if (i == 15) sb_q.push_back(w);
      send_bit(w[i], 1'b0, 4'd0);
    end
    idle(1);
    total++;
    if (out !== w || strobe_cnt - s0 !== 1)
      $display("FAIL abort_word: got out=%h strobes=%0d expected %h 1", out, strobe_cnt - s0, w);
    else passed++;
    check_queue_empty("abort");
    for (int i = 0; i < 9; i++) send_bit(1'b1, 1'b0, 4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out !== 16'h0000 || pos !== 4'd0 || busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL midframe_reset: got out=%h pos=%0d busy=%b ov=%b expected 0000 0 0 0", out, pos, busy, out_valid);
    else passed++;
    do_reset();
  endtask

  task automatic test_explicit_sel();
    do_reset();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 4'd0);
    in = 1'b1; load_sel = 1'b1; sel = 4'd5; in_valid = 1'b0;
    @(posedge clk); #1;
    load_sel = 1'b0;
    total++;
    if (pos !== 4'd4) $display("FAIL sel_no_valid: got pos=%0d expected 4", pos);
    else passed++;
    sb_q.push_back(16'h800F);
    send_bit(1'b1, 1'b1, 4'd15);
    total++;
    if (out !== 16'h800F || out_valid !== 1'b1 || pos !== 4'd0)
      $display("FAIL sel_frame_a: got out=%h ov=%b pos=%0d expected 800f 1 0", out, out_valid, pos);
    else passed++;
    send_bit(1'b1, 1'b1, 4'd14);
    total++;
    if (pos !== 4'd15 || out_valid !== 1'b0 || out !== 16'h800F)
      $display("FAIL sel_b_pos: got pos=%0d ov=%b out=%h expected 15 0 800f", pos, out_valid, out);
    else passed++;
    sb_q.push_back(16'hC000);
    send_bit(1'b1, 1'b0, 4'd0);
    total++;
    if (out !== 16'hC000 || out_valid !== 1'b1 || pos !== 4'd0)
      $display("FAIL sel_frame_b: got out=%h ov=%b pos=%0d expected c000 1 0", out, out_valid, pos);
    else passed++;
    idle(1);
    check_queue_empty("sel");
  endtask

  task automatic test_simultaneous();
    logic [15:0] w;
    int s0;
    w  = 16'h0F0F;
    s0 = strobe_cnt;
    for (int i = 0; i < 15; i++) send_bit(w[i], 1'b0, 4'd0);
    clr = 1'b1;
    send_bit(1'b1, 1'b0, 4'd0);
    clr = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out !== 16'hC000 || pos !== 4'd0)
      $display("FAIL simul_clr: got ov=%b out=%h pos=%0d expected 0 c000 0", out_valid, out, pos);
    else passed++;
    idle(2);
    total++;
    if (strobe_cnt - s0 !== 0) $display("FAIL simul_strobes: got %0d expected 0", strobe_cnt - s0);
    else passed++;
    check_queue_empty("simul");
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    strobe_cnt = 0;
    test_reset();
    test_basic();
    test_gapped();
    test_back_to_back();
    test_abort();
    test_explicit_sel();
    test_simultaneous();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/demux1to16_deser.md
# demux1to16_deser

Serial-to-parallel demultiplexing register: the receive-side counterpart of the 16:1 bit-select mux. Each accepted serial bit is routed into one of 16 word positions, selected by an internal 4-bit position counter or by an explicit select. Once position 15 is written, the assembled 16-bit word is published with a one-cycle strobe. The block sits after a 16:1 serializer driven by a 0..15 select sweep, and reconstructs the original word in the same bit order.

## Interface
- No parameters; word width fixed at 16, select width fixed at 4.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  1  serial data bit.
- in_valid  input  1  `in` is sampled on this edge when high.
- load_sel  input  1  when high with `in_valid`, write to position `sel` instead of the counter position.
- sel  input  4  explicit target position, used only when `load_sel` is high.
- clr  input  1  synchronous frame abort.
- out  output  16  last completed word.
- out_valid  output  1  one-cycle strobe: `out` was updated this cycle.
- pos  output  4  next position to be written (counter value).
- busy  output  1  high when the frame is partially filled (`pos != 0`).

## Operation
- Internal state:
  - `acc[15:0]` accumulation word.
  - `pos[3:0]` position counter.
  - `out[15:0]`, `out_valid` output registers.
- Write target `t`:
  - `t = sel` when `load_sel` is high.
  - `t = pos` otherwise.
- Accepted bit (`in_valid=1`, `clr=0`):
  - `acc[t] <= in`.
  - `pos <= t + 1`, mod 16 (15 wraps to 0).
- Frame completion (`t == 15` on an accepted bit):
  - `out <= acc` with bit 15 replaced by `in`.
  - `out_valid <= 1`.
  - `acc <= 0`; `pos <= 0`.
- Bit order: position 0 is received first, so the word is LSB-first. This matches a serializer sweeping select 0..15 over `in[15:0]`.
- Positions skipped via `load_sel` keep their current `acc` value: 0 if not yet written in this frame.
- `clr=1`:
  - `acc <= 0`; `pos <= 0`; `out_valid <= 0`.
  - Any bit presented the same cycle is dropped.
  - `out` holds its value.
- `in_valid=0`:
  - `acc`, `pos`, `out` hold.
  - `out_valid <= 0`.
  - Gaps of any length between bits are legal.
- `load_sel` without `in_valid` has no effect.
- `out` changes only on frame completion and holds between completions.

## Timing
- Reset values (asynchronous, effective immediately while `rst_n=0`):
  - `out = 16'h0000`, `out_valid = 0`.
  - `pos = 0`, `busy = 0`, `acc = 0`.
- First active edge after `rst_n` rises is a normal cycle; no extra recovery cycle.
- Latency:
  - `out` and `out_valid` are registered, and update on the same edge that samples the 16th (position-15) bit.
  - Visible one cycle after the bit is presented.
  - `out_valid` is high for exactly one cycle per completed frame.
- Back-to-back frames: a bit may be accepted on the cycle `out_valid` is high, with no bubble. That bit goes to position 0 of the next frame.
- `busy` is combinational from `pos` (`pos != 0`).
- Simultaneous events: priority is `rst_n` > `clr` > `in_valid`.
- Reset mid-frame: the partial word is discarded and `out` returns to 0.

## Test plan
- **Basic word:** reset, then 16 consecutive `in_valid` bits of `16'hABCD`, LSB first.
  - `out = 16'hABCD` and `out_valid=1` for one cycle after the 16th edge.
  - `pos` steps 0..15 then back to 0; `busy` is low afterwards.
- **Gapped input:** same word with `in_valid` deasserted for 1–3 random cycles between bits.
  - Identical result; `out_valid` appears once only.
- **Back-to-back frames:** `16'h1234` immediately followed by `16'hFFFF`.
  - Two `out_valid` pulses 16 cycles apart; `out = 16'h1234`, then `16'hFFFF`.
- **Abort and reset mid-frame:**
  - `clr` after 7 bits, then a full `16'h00F0` → `out = 16'h00F0`; the prior `out` is held until then; no spurious strobe.
  - Repeat with `rst_n` low at bit 9 → `out = 0` immediately.
- **Explicit select:**
  - Frame A: bits 0..3 = 1 via the counter, then `load_sel=1, sel=15, in=1`. Expect `out = 16'h800F`, `out_valid=1`, `pos=0`.
  - Frame B: `load_sel=1, sel=14, in=1` → `pos=15`; then one counter bit of 1 completes the frame with `out = 16'hC000`.
- **Simultaneous events:** `clr=1` with `in_valid=1` on the 16th bit.
  - No `out_valid`, `out` unchanged, `pos=0`.
